// File: rtl/cpu_pkg.sv
// Shared widths, FSM state and opcode class encodings, and opcode field constants.
// Purely declarative: no latency and no flow control.
package cpu_pkg;

    localparam int REG_WIDTH  = 8;
    localparam int ADDR_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_EXEC,
        ST_WRITE,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        CL_READ,
        CL_STORE,
        CL_IMM,
        CL_ACC,
        CL_RMW,
        CL_NOP
    } op_class_t;

    localparam logic [1:0] CC_G0 = 2'b00;
    localparam logic [1:0] CC_G1 = 2'b01;
    localparam logic [1:0] CC_G2 = 2'b10;
    localparam logic [1:0] CC_G3 = 2'b11;

    localparam logic [2:0] AAA_STORE   = 3'b100;
    localparam logic [2:0] AAA_LOAD    = 3'b101;
    localparam logic [2:0] BBB_IMM     = 3'b000;
    localparam logic [2:0] BBB_G1_IMM  = 3'b010;
    localparam logic [2:0] BBB_ACC     = 3'b010;

endpackage

// File: rtl/op_classify.sv
// Combinational opcode classifier (cc/bbb/aaa fields to operand class).
// Zero latency, no flow control; earlier rules take priority over later ones.
module op_classify
    import cpu_pkg::*;
(
    input  logic [7:0] i_opcode,
    output op_class_t  o_class
);

    logic [1:0] w_cc;
    logic [2:0] w_bbb;
    logic [2:0] w_aaa;

    assign w_cc  = i_opcode[1:0];
    assign w_bbb = i_opcode[4:2];
    assign w_aaa = i_opcode[7:5];

    always_comb begin
        o_class = CL_READ;
        if (w_aaa == AAA_STORE && w_cc != CC_G3) begin
            o_class = CL_STORE;
        end else if ((w_cc == CC_G1 && w_bbb == BBB_G1_IMM) ||
                     (w_cc != CC_G1 && w_bbb == BBB_IMM && w_aaa[2])) begin
            o_class = CL_IMM;
        end else if (w_cc == CC_G2 && w_bbb == BBB_ACC) begin
            o_class = CL_ACC;
        end else if (w_cc == CC_G2 && w_aaa != AAA_STORE && w_aaa != AAA_LOAD) begin
            o_class = CL_RMW;
        end else if (w_cc == CC_G3 ||
                     (w_cc == CC_G0 && (w_aaa == 3'b000 || w_aaa == 3'b010 || w_aaa == 3'b011))) begin
            o_class = CL_NOP;
        end
    end

endmodule

// File: rtl/operand_stage.sv
// Operand fetch/writeback sequencer between instruction fetcher, memory and execute unit.
// Latency from capture to done: 1..4 cycles plus execute wait; stalls in EXEC until result_valid.
module operand_stage
    import cpu_pkg::*;
#(
    parameter int REG_WIDTH  = cpu_pkg::REG_WIDTH,
    parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
    input  logic                  phi1,
    input  logic                  reset,
    input  logic                  instruction_ready,
    input  logic [7:0]            instruction_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [REG_WIDTH-1:0]  imm_in,
    input  logic [REG_WIDTH-1:0]  reg_a,
    input  logic [REG_WIDTH-1:0]  reg_x,
    input  logic [REG_WIDTH-1:0]  reg_y,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    input  logic [REG_WIDTH-1:0]  result_in,
    input  logic                  result_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]  mem_wdata,
    output logic                  mem_rd,
    output logic                  mem_we,
    output logic                  op_valid,
    output logic [REG_WIDTH-1:0]  operand,
    output logic [7:0]            opcode_out,
    output logic                  instruction_done
);

    state_t                r_state;
    op_class_t             r_class;
    logic                  r_rdy_prev;
    logic                  r_rdy_low_seen;
    logic [7:0]            r_opcode;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [REG_WIDTH-1:0]  r_mem_wdata;
    logic [REG_WIDTH-1:0]  r_operand;
    logic                  r_mem_rd;
    logic                  r_mem_we;
    logic                  r_op_valid;
    logic                  r_done;

    op_class_t             w_class;
    logic                  w_capture;
    logic [REG_WIDTH-1:0]  w_store_reg;

    op_classify u_classify (
        .i_opcode (instruction_in),
        .o_class  (w_class)
    );

    // A level already high when reset releases must drop once before it can capture.
    assign w_capture = instruction_ready && !r_rdy_prev && r_rdy_low_seen;

    always_comb begin
        w_store_reg = reg_y;
        if (instruction_in[1:0] == CC_G1) begin
            w_store_reg = reg_a;
        end else if (instruction_in[1:0] == CC_G2) begin
            w_store_reg = reg_x;
        end
    end

    always_ff @(posedge phi1 or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_class        <= CL_READ;
            r_rdy_prev     <= 1'b0;
            r_rdy_low_seen <= 1'b0;
            r_opcode       <= '0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_operand      <= '0;
            r_mem_rd       <= 1'b0;
            r_mem_we       <= 1'b0;
            r_op_valid     <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_rdy_prev <= instruction_ready;
            if (!instruction_ready) begin
                r_rdy_low_seen <= 1'b1;
            end
            r_mem_rd <= 1'b0;
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_capture) begin
                        r_opcode   <= instruction_in;
                        r_mem_addr <= addr_in;
                        r_class    <= w_class;
                        case (w_class)
                            CL_STORE: begin
                                r_state     <= ST_WRITE;
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= w_store_reg;
                            end
                            CL_READ, CL_RMW: begin
                                r_state  <= ST_RD_REQ;
                                r_mem_rd <= 1'b1;
                            end
                            CL_IMM: begin
                                r_state    <= ST_EXEC;
                                r_op_valid <= 1'b1;
                                r_operand  <= imm_in;
                            end
                            CL_ACC: begin
                                r_state    <= ST_EXEC;
                                r_op_valid <= 1'b1;
                                r_operand  <= reg_a;
                            end
                            default: begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_RD_REQ: begin
                    r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    r_state    <= ST_EXEC;
                    r_operand  <= mem_rdata;
                    r_op_valid <= 1'b1;
                end
                ST_EXEC: begin
                    if (result_valid) begin
                        r_op_valid <= 1'b0;
                        if (r_class == CL_RMW) begin
                            r_state     <= ST_WRITE;
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= result_in;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_op_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr         = r_mem_addr;
    assign mem_wdata        = r_mem_wdata;
    assign mem_rd           = r_mem_rd;
    assign mem_we           = r_mem_we;
    assign op_valid         = r_op_valid;
    assign operand          = r_operand;
    assign opcode_out       = r_opcode;
    assign instruction_done = r_done;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: hand-computed vectors checked with immediate assertions.
module tb_operand_stage;

    logic        phi1;
    logic        reset;
    logic        instruction_ready;
    logic [7:0]  instruction_in;
    logic [15:0] addr_in;
    logic [7:0]  imm_in;
    logic [7:0]  reg_a, reg_x, reg_y;
    logic [7:0]  mem_rdata;
    logic [7:0]  result_in;
    logic        result_valid;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd;
    logic        mem_we;
    logic        op_valid;
    logic [7:0]  operand;
    logic [7:0]  opcode_out;
    logic        instruction_done;

    logic [7:0]  mem_word;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_done  = 0;
    int          n_rd    = 0;
    int          n_we    = 0;
    int          n_opv   = 0;
    int          n_both  = 0;
    int          s_done, s_rd, s_we, s_opv;

    operand_stage dut (
        .phi1             (phi1),
        .reset            (reset),
        .instruction_ready(instruction_ready),
        .instruction_in   (instruction_in),
        .addr_in          (addr_in),
        .imm_in           (imm_in),
        .reg_a            (reg_a),
        .reg_x            (reg_x),
        .reg_y            (reg_y),
        .mem_rdata        (mem_rdata),
        .result_in        (result_in),
        .result_valid     (result_valid),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rd           (mem_rd),
        .mem_we           (mem_we),
        .op_valid         (op_valid),
        .operand          (operand),
        .opcode_out       (opcode_out),
        .instruction_done (instruction_done)
    );

    initial phi1 = 1'b0;
    always #5 phi1 = ~phi1;

    // Memory answers one cycle after the read strobe.
    always @(posedge phi1) begin
        mem_rdata <= mem_rd ? mem_word : 8'h00;
    end

    always @(negedge phi1) begin
        if (instruction_done) n_done++;
        if (mem_rd) n_rd++;
        if (mem_we) n_we++;
        if (op_valid) n_opv++;
        if (mem_rd && mem_we) n_both++;
    end

    task automatic step();
        @(posedge phi1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_done = n_done;
        s_rd   = n_rd;
        s_we   = n_we;
        s_opv  = n_opv;
    endtask

    task automatic issue(input logic [7:0] op, input logic [15:0] addr, input logic [7:0] imm);
        instruction_in    = op;
        addr_in           = addr;
        imm_in            = imm;
        instruction_ready = 1'b1;
        step();
        instruction_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        instruction_ready = 1'b0;
        instruction_in = 8'h00; addr_in = 16'h0000; imm_in = 8'h00;
        reg_a = 8'h77; reg_x = 8'h11; reg_y = 8'h22;
        result_in = 8'h00; result_valid = 1'b0;
        mem_word = 8'h00;
        step(); step();
        chk("rst_mem_rd", mem_rd, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_done", instruction_done, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_opcode", opcode_out, 8'h00);
        reset = 1'b0;
        step(); step();

        // LDA abs: read, two idle EXEC cycles, then done on the cycle after result_valid
        mem_word = 8'h5A;
        snap();
        issue(8'hAD, 16'h1234, 8'h00);
        chk("lda_rd", mem_rd, 1'b1);
        chk("lda_addr", mem_addr, 16'h1234);
        chk("lda_opcode", opcode_out, 8'hAD);
        chk("lda_opv_early", op_valid, 1'b0);
        step();
        chk("lda_rd_once", mem_rd, 1'b0);
        step();
        chk("lda_opv", op_valid, 1'b1);
        chk("lda_operand", operand, 8'h5A);
        step(); step();
        chk("lda_opv_hold", op_valid, 1'b1);
        chk("lda_no_done_yet", instruction_done, 1'b0);
        result_in = 8'h5A; result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        chk("lda_done", instruction_done, 1'b1);
        chk("lda_opv_drop", op_valid, 1'b0);
        step();
        chk("lda_done_pulse", instruction_done, 1'b0);
        chk("lda_rd_cnt", n_rd - s_rd, 1);
        chk("lda_we_cnt", n_we - s_we, 0);
        step();

        // STA zpg: write reg_a, done two cycles after capture
        snap();
        issue(8'h85, 16'h0042, 8'h00);
        chk("sta_we", mem_we, 1'b1);
        chk("sta_wdata", mem_wdata, 8'h77);
        chk("sta_addr", mem_addr, 16'h0042);
        chk("sta_no_done", instruction_done, 1'b0);
        step();
        chk("sta_we_once", mem_we, 1'b0);
        chk("sta_done", instruction_done, 1'b1);
        step();
        chk("sta_opv_cnt", n_opv - s_opv, 0);
        chk("sta_rd_cnt", n_rd - s_rd, 0);
        step();

        // STX zpg selects reg_x
        issue(8'h86, 16'h0010, 8'h00);
        chk("stx_wdata", mem_wdata, 8'h11);
        step(); step(); step();

        // INC abs: stray result_valid in RD_REQ must be ignored
        mem_word = 8'h0F;
        snap();
        issue(8'hEE, 16'h0200, 8'h00);
        chk("inc_rd", mem_rd, 1'b1);
        result_in = 8'hEE; result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        chk("inc_no_opv_wait", op_valid, 1'b0);
        step();
        chk("inc_opv", op_valid, 1'b1);
        chk("inc_operand", operand, 8'h0F);
        result_in = 8'h10; result_valid = 1'b1;
        step();
        result_valid = 1'b0; result_in = 8'h00;
        chk("inc_we", mem_we, 1'b1);
        chk("inc_wdata", mem_wdata, 8'h10);
        chk("inc_addr", mem_addr, 16'h0200);
        chk("inc_opv_drop", op_valid, 1'b0);
        chk("inc_not_done", instruction_done, 1'b0);
        step();
        chk("inc_done", instruction_done, 1'b1);
        chk("inc_we_once", mem_we, 1'b0);
        step(); step();

        // LDX #imm: no memory traffic, done the cycle after result_valid
        snap();
        issue(8'hA2, 16'h0000, 8'h33);
        chk("ldx_opv", op_valid, 1'b1);
        chk("ldx_operand", operand, 8'h33);
        result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        chk("ldx_done", instruction_done, 1'b1);
        step();
        chk("ldx_rd_cnt", n_rd - s_rd, 0);
        chk("ldx_we_cnt", n_we - s_we, 0);
        step();

        // ASL A: operand is reg_a
        reg_a = 8'h9C;
        issue(8'h0A, 16'h0000, 8'h00);
        chk("acc_operand", operand, 8'h9C);
        result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        step(); step();

        // CLC: NOP completes one cycle after capture
        issue(8'h18, 16'h0000, 8'h00);
        chk("nop_done", instruction_done, 1'b1);
        step(); step();

        // Reset during RD_WAIT with instruction_ready held across release
        mem_word = 8'hA5;
        issue(8'hAD, 16'h4321, 8'h00);
        step();
        instruction_ready = 1'b1;
        reset = 1'b1;
        #1;
        snap();
        chk("rstmid_opv", op_valid, 1'b0);
        chk("rstmid_addr", mem_addr, 16'h0000);
        chk("rstmid_opcode", opcode_out, 8'h00);
        step(); step();
        reset = 1'b0;
        repeat (6) step();
        chk("rstmid_done_cnt", n_done - s_done, 0);
        chk("rstmid_we_cnt", n_we - s_we, 0);
        chk("rstmid_rd_cnt", n_rd - s_rd, 0);
        instruction_ready = 1'b0;
        step();
        issue(8'h18, 16'h0000, 8'h00);
        chk("rstmid_recapture", instruction_done, 1'b1);
        step(); step();

        // instruction_ready re-pulsed and held during EXEC is ignored
        snap();
        issue(8'hA2, 16'h0000, 8'h44);
        step();
        instruction_ready = 1'b1;
        step();
        chk("repulse_opv", op_valid, 1'b1);
        result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        repeat (5) step();
        chk("repulse_done_cnt", n_done - s_done, 1);
        chk("repulse_idle", op_valid, 1'b0);
        instruction_ready = 1'b0;
        step();

        chk("rd_we_exclusive", n_both, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
